// File: rtl/module_mem_pkg.sv
// Shared widths, flag layout and FSM encodings for the memory-access stage.
package module_mem_pkg;

  localparam int DATA_BUS_W     = 64;
  localparam int REG_ADDR_BUS_W = 5;
  localparam int FLAG_BUS_W     = 4;
  localparam int FLAG_Z_IDX     = 2;

  typedef logic [DATA_BUS_W-1:0]     DataBus;
  typedef logic [REG_ADDR_BUS_W-1:0] RegAddrBus;
  typedef logic [FLAG_BUS_W-1:0]     FlagBus;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_BUSY = 2'd1,
    MEM_DONE = 2'd2
  } memState_e;

endpackage

// File: rtl/module_mem_wb.sv
// MEM/WB pipeline register; a stalled cycle injects a bubble by clearing RegWrite only.
module mem_wb #(
  parameter int DATA_W = 64,
  parameter int REG_AW = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              stall_i,
  input  logic [REG_AW-1:0] waddr_i,
  input  logic              RegWrite_i,
  input  logic              MemtoReg_i,
  input  logic [DATA_W-1:0] result_i,
  input  logic [DATA_W-1:0] rdata_i,
  output logic [REG_AW-1:0] wb_waddr_o,
  output logic              wb_RegWrite_o,
  output logic              wb_MemtoReg_o,
  output logic [DATA_W-1:0] wb_result_o,
  output logic [DATA_W-1:0] wb_rdata_o
);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wb_waddr_o    <= '0;
      wb_RegWrite_o <= 1'b0;
      wb_MemtoReg_o <= 1'b0;
      wb_result_o   <= '0;
      wb_rdata_o    <= '0;
    end else if (stall_i) begin
      wb_RegWrite_o <= 1'b0;
    end else begin
      wb_waddr_o    <= waddr_i;
      wb_RegWrite_o <= RegWrite_i;
      wb_MemtoReg_o <= MemtoReg_i;
      wb_result_o   <= result_i;
      wb_rdata_o    <= rdata_i;
    end
  end

endmodule

// File: rtl/module_mem.sv
// Memory-access stage: multi-cycle data-memory handshake, branch resolution,
// front-end stall and the MEM/WB register with its forwarding value.
module module_mem
  import module_mem_pkg::*;
#(
  parameter int DATA_W = DATA_BUS_W,
  parameter int REG_AW = REG_ADDR_BUS_W,
  parameter int FLAG_W = FLAG_BUS_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [FLAG_W-1:0] mem_flags_i,
  input  logic [DATA_W-1:0] mem_result_i,
  input  logic [DATA_W-1:0] mem_reg2_i,
  input  logic [REG_AW-1:0] mem_waddr_i,
  input  logic              mem_MemRead_i,
  input  logic              mem_MemWrite_i,
  input  logic              mem_MemtoReg_i,
  input  logic              mem_RegWrite_i,
  input  logic [DATA_W-1:0] mem_add_i,
  input  logic              mem_isZeroBranch_i,
  input  logic              mem_isUnconBranch_i,
  input  logic              mem_isNZBranch_i,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [DATA_W-1:0] dmem_addr_o,
  output logic [DATA_W-1:0] dmem_wdata_o,
  input  logic [DATA_W-1:0] dmem_rdata_i,
  input  logic              dmem_ack_i,
  output logic              mem_stall_o,
  output logic              mem_pcsrc_o,
  output logic [DATA_W-1:0] mem_target_o,
  output logic [DATA_W-1:0] f_ALURes_o,
  output logic [REG_AW-1:0] wb_waddr_o,
  output logic              wb_RegWrite_o,
  output logic              wb_MemtoReg_o,
  output logic [DATA_W-1:0] wb_result_o,
  output logic [DATA_W-1:0] wb_rdata_o,
  output logic [DATA_W-1:0] f_Out_o
);

  memState_e         state_q, state_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic              isAccess;
  logic              isLoad;
  logic              flagZ;
  logic              unusedFlags;
  logic [DATA_W-1:0] wbRdataIn;

  assign isAccess = mem_MemRead_i | mem_MemWrite_i;
  assign isLoad   = mem_MemRead_i & ~mem_MemWrite_i;
  assign flagZ    = mem_flags_i[FLAG_Z_IDX];
  assign unusedFlags = ^{mem_flags_i[FLAG_W-1:FLAG_Z_IDX+1], mem_flags_i[FLAG_Z_IDX-1:0]};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= MEM_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      MEM_IDLE: if (isAccess) state_d = MEM_BUSY;
      MEM_BUSY: if (dmem_ack_i) state_d = MEM_DONE;
      MEM_DONE: state_d = MEM_IDLE;
      default:  state_d = MEM_IDLE;
    endcase
  end

  always_comb begin
    mem_stall_o = 1'b0;
    dmem_req_o  = 1'b0;
    case (state_q)
      MEM_IDLE: mem_stall_o = isAccess;
      MEM_BUSY: begin
        mem_stall_o = 1'b1;
        dmem_req_o  = 1'b1;
      end
      default: begin
        mem_stall_o = 1'b0;
        dmem_req_o  = 1'b0;
      end
    endcase
  end

  // Request fields are captured on entry so they stay stable for the whole BUSY window.
  always_comb begin
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    rdata_d = rdata_q;
    if (state_q == MEM_IDLE && isAccess) begin
      addr_d  = mem_result_i;
      wdata_d = mem_reg2_i;
      we_d    = mem_MemWrite_i;
    end
    if (state_q == MEM_BUSY && dmem_ack_i && !we_q) begin
      rdata_d = dmem_rdata_i;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      rdata_q <= rdata_d;
    end
  end

  assign dmem_addr_o  = addr_q;
  assign dmem_wdata_o = wdata_q;
  assign dmem_we_o    = we_q & (state_q == MEM_BUSY);

  assign mem_pcsrc_o  = ~mem_stall_o & (mem_isUnconBranch_i |
                                        (mem_isZeroBranch_i & flagZ) |
                                        (mem_isNZBranch_i & ~flagZ));
  assign mem_target_o = mem_add_i;
  assign f_ALURes_o   = mem_result_i;

  assign wbRdataIn = isLoad ? rdata_q : '0;

  mem_wb #(
    .DATA_W(DATA_W),
    .REG_AW(REG_AW)
  ) u_mem_wb (
    .clock        (clock),
    .reset        (reset),
    .stall_i      (mem_stall_o),
    .waddr_i      (mem_waddr_i),
    .RegWrite_i   (mem_RegWrite_i),
    .MemtoReg_i   (mem_MemtoReg_i),
    .result_i     (mem_result_i),
    .rdata_i      (wbRdataIn),
    .wb_waddr_o   (wb_waddr_o),
    .wb_RegWrite_o(wb_RegWrite_o),
    .wb_MemtoReg_o(wb_MemtoReg_o),
    .wb_result_o  (wb_result_o),
    .wb_rdata_o   (wb_rdata_o)
  );

  assign f_Out_o = wb_MemtoReg_o ? wb_rdata_o : wb_result_o;

endmodule

// File: doc/module_mem.md
Name: module_mem

Overview:
- Memory-access stage of the ARMv8 five-stage pipeline. Consumes the EX/MEM register outputs (result, store data, write address, memory/writeback controls, branch target, branch-type flags, NZCV flags).
- Drives a multi-cycle data-memory request/acknowledge interface, resolves CBZ/CBNZ/B branches, and stalls the front of the pipeline while an access is outstanding.
- Contains the MEM/WB pipeline register and presents the forwarding values (f_ALURes, f_Out) consumed by the EX stage.

Parameters:
- DATA_W, 64, data/address width
- REG_AW, 5, register-file address width
- FLAG_W, 4, flag vector width, ordered N Z C V, so Z = bit 2

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- mem_flags_i  in  FLAG_W  NZCV from EX/MEM
- mem_result_i  in  DATA_W  ALU result; memory address for loads/stores
- mem_reg2_i  in  DATA_W  store data
- mem_waddr_i  in  REG_AW  destination register
- mem_MemRead_i, mem_MemWrite_i, mem_MemtoReg_i, mem_RegWrite_i  in  1 each  controls
- mem_add_i  in  DATA_W  branch target (PC + imm<<2)
- mem_isZeroBranch_i, mem_isUnconBranch_i, mem_isNZBranch_i  in  1 each  branch type
- dmem_req_o  out  1  memory request
- dmem_we_o  out  1  1 = write
- dmem_addr_o  out  DATA_W  latched address
- dmem_wdata_o  out  DATA_W  latched store data
- dmem_rdata_i  in  DATA_W  load data, valid with ack
- dmem_ack_i  in  1  access complete
- mem_stall_o  out  1  freeze PC, IF/ID, ID/EX, EX/MEM
- mem_pcsrc_o  out  1  take branch
- mem_target_o  out  DATA_W  branch target, equals mem_add_i
- f_ALURes_o  out  DATA_W  equals mem_result_i, forwarding source from MEM
- wb_waddr_o  out  REG_AW  MEM/WB register: destination
- wb_RegWrite_o  out  1  MEM/WB register: write enable
- wb_MemtoReg_o  out  1  MEM/WB register: select
- wb_result_o  out  DATA_W  MEM/WB register: ALU result
- wb_rdata_o  out  DATA_W  MEM/WB register: load data
- f_Out_o  out  DATA_W  wb_MemtoReg_o ? wb_rdata_o : wb_result_o (writeback/forward value)

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM goes to IDLE.
  - dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o are 0.
  - All wb_* outputs and the internal read-data latch are 0.
  - Reset mid-access abandons the access, and any later ack is ignored.
- Access = mem_MemRead_i | mem_MemWrite_i. If both are set, the access is a write and no read data is captured.
- FSM states: IDLE, BUSY, DONE.
  - IDLE, access present:
    - mem_stall_o = 1, combinational.
    - Latch address = mem_result_i, wdata = mem_reg2_i, we = mem_MemWrite_i.
    - Next state BUSY.
  - IDLE, no access: mem_stall_o = 0 and the state stays IDLE.
  - BUSY:
    - dmem_req_o = 1 and mem_stall_o = 1.
    - Address, wdata and we are held stable.
    - On dmem_ack_i = 1: latch dmem_rdata_i (reads only), next state DONE. dmem_req_o drops in the DONE cycle.
  - DONE:
    - mem_stall_o = 0, so the held instruction completes and the MEM/WB register loads it this edge.
    - Next state IDLE.
- dmem_ack_i is ignored in IDLE and DONE.
- Minimum memory-instruction occupancy: 3 cycles (IDLE, BUSY with ack, DONE). Non-memory instructions take 1 cycle.
- Back-to-back memory instructions: the following one enters IDLE and stalls again. No pipelining of requests.
- Upstream contract: while mem_stall_o = 1, all *_i inputs are held constant.
- MEM/WB register on each rising edge:
  - mem_stall_o = 0: load waddr, RegWrite, MemToReg, result, and rdata (latched value for loads, otherwise 0).
  - mem_stall_o = 1: load a bubble (wb_RegWrite_o = 0). The other wb fields hold.
- Branch resolution is combinational:
  - mem_pcsrc_o = ~mem_stall_o & (Uncon | (ZeroBranch & Z) | (NZBranch & ~Z)).
  - Branch instructions never access memory.
- No alignment checking. The address is passed through unmodified.

Decomposition:
- Shared defines (existing defines.v style): DataBus, RegAddrBus, FlagBus, FLAG_Z_IDX = 2, FSM state encodings MEM_IDLE = 2'd0, MEM_BUSY = 2'd1, MEM_DONE = 2'd2.
- One natural sub-module, mem_wb: the MEM/WB pipeline register with bubble-on-stall, in the same style as ex_mem.
- FSM, memory latches and branch logic stay in module_mem.

Test Plan:
- Reset release with idle inputs -> all outputs 0, mem_stall_o = 0, state IDLE. Assert reset during BUSY -> dmem_req_o drops immediately, and an ack one cycle later has no effect.
- LDUR: MemRead = 1, result = 0x100, waddr = 5, ack on the 3rd BUSY cycle with rdata = 0xDEAD_BEEF -> stall high for 4 cycles, dmem_addr_o = 0x100. Next edge: wb_waddr_o = 5, wb_RegWrite_o = 1, f_Out_o = 0xDEADBEEF.
- STUR: MemWrite = 1, result = 0x208, reg2 = 0x1234, ack immediate -> dmem_we_o = 1, dmem_wdata_o = 0x1234 for 1 cycle. Exactly 3 cycles total, wb_RegWrite_o = 0 (store has RegWrite = 0).
- ADD through MEM: RegWrite = 1, result = 42, waddr = 3 -> no stall, f_ALURes_o = 42 the same cycle. Next edge: wb_result_o = 42, f_Out_o = 42.
- CBZ with flags = 4'b0100 -> mem_pcsrc_o = 1, mem_target_o = mem_add_i. CBNZ with the same flags -> 0. B with flags = 0 -> 1.
- Two consecutive LDURs (0x10, 0x18) -> two separate request windows, a wb_RegWrite_o = 0 bubble while each is stalled, and the second load's rdata is not corrupted by the first.
